// File: rtl/result_histogram.sv
// Four-bin occurrence histogram of 3-bit result codes with a saturating
// counter per bin and a ready/valid dump stream that clears the bins on completion.
module result_histogram #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  input  logic             clear,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic [2:0]       last_code,
  output logic             code_changed
);

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  logic [CNT_W-1:0] bin_val [4];
  logic [1:0]       in_bin;
  logic             accept;
  logic             code_match;
  logic             dump_last;
  logic             zero_all;

  // Codes 3..7 all land in the miss bin.
  assign in_bin     = (in_code > 3'd2) ? 2'd3 : in_code[1:0];
  assign code_match = (in_code <= 3'd2);
  assign accept     = (state_reg == IDLE) && in_valid && !clear;
  assign dump_last  = (state_reg == DUMP) && out_ready && (out_idx == 2'd3);
  assign zero_all   = ((state_reg == IDLE) && clear) || dump_last;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bin
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n || zero_all) begin
          cnt_reg <= '0;
        end else if (accept && (in_bin == 2'(gi)) && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign bin_val[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_idx      <= 2'd0;
      last_code    <= 3'd0;
      code_changed <= 1'b0;
    end else begin
      code_changed <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept && code_match) begin
            last_code    <= in_code;
            code_changed <= (in_code != last_code);
          end
          if (!clear && dump_req) begin
            state_reg <= DUMP;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_idx   <= 2'd0;
          end
        end
        DUMP: begin
          if (out_ready) begin
            if (out_idx == 2'd3) begin
              state_reg <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_idx   <= 2'd0;
            end else begin
              out_idx <= out_idx + 2'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_idx   <= 2'd0;
        end
      endcase
    end
  end

  // Bins are frozen during a dump, so the muxed count stays stable while stalled.
  assign out_count = out_valid ? bin_val[out_idx] : '0;

endmodule
